// File: rtl/dot_matrix_pkg.sv
// dot_matrix_pkg: shared widths, constants and default geometry for the dot-matrix scanner.
package dot_matrix_pkg;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int MAX_ROWS = 16;
    localparam logic [MAX_ROWS-1:0] BLANK_ROW = '1;

    function automatic int cnt_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int row_w(int rows);
        return cnt_w(rows);
    endfunction

    function automatic int col_w(int cols);
        return cnt_w(cols);
    endfunction
endpackage

// File: rtl/dot_matrix_framebuf.sv
// dot_matrix_framebuf: double-buffered ROWS x COLS frame memory; host writes the back buffer, swap flips front/back.
module dot_matrix_framebuf
    import dot_matrix_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                   clk_div,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [row_w(ROWS)-1:0] wr_addr,
    input  logic [COLS-1:0]        wr_data,
    input  logic [row_w(ROWS)-1:0] rd_addr,
    input  logic                   swap,
    output logic [COLS-1:0]        rd_data
);
    localparam int RW = row_w(ROWS);
    localparam logic [RW:0] N_ROWS = (RW+1)'(ROWS);

    logic [COLS-1:0] buf_a [ROWS];
    logic [COLS-1:0] buf_b [ROWS];
    logic front_b;
    logic wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < N_ROWS);

    // The back buffer is chosen by the pre-swap select, so a write on the swap edge becomes visible immediately.
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            front_b <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else begin
            front_b <= front_b ^ swap;
            if (wr_ok && front_b)
                buf_a[wr_addr] <= wr_data;
            if (wr_ok && !front_b)
                buf_b[wr_addr] <= wr_data;
        end
    end

    assign rd_data = front_b ? buf_b[rd_addr] : buf_a[rd_addr];
endmodule

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: row-scan LED matrix driver with dwell, anti-ghost blanking and tear-free frame commit.
// Define DOT_MATRIX_SCROLL_EN to add per-frame horizontal scrolling (scroll_en, scroll_left).
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DWELL = 1,
    parameter int BLANK = 0
) (
    input  logic                   clk_div,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wr_en,
    input  logic [row_w(ROWS)-1:0] wr_addr,
    input  logic [COLS-1:0]        wr_data,
    input  logic                   commit,
`ifdef DOT_MATRIX_SCROLL_EN
    input  logic                   scroll_en,
    input  logic                   scroll_left,
`endif
    output logic                   commit_pending,
    output logic                   frame_start,
    output logic [ROWS-1:0]        dot_row,
    output logic [COLS-1:0]        dot_col
);
    localparam int RW = row_w(ROWS);
    localparam int DW = cnt_w(DWELL);
    localparam logic [RW-1:0] R_LAST  = RW'(ROWS-1);
    localparam logic [DW-1:0] D_LAST  = DW'(DWELL-1);
    localparam logic [DW:0]   D_BLANK = (DW+1)'(BLANK);

    logic [RW-1:0]   r;
    logic [DW-1:0]   d;
    logic [COLS-1:0] rd_data;
    logic [COLS-1:0] col_data;
    logic [ROWS-1:0] row_sel;
    logic boundary;
    logic swap;
    logic lit;

    assign boundary = en && r == R_LAST && d == D_LAST;
    // While disabled any pending swap is taken at once so the restart shows the new frame.
    assign swap     = (commit_pending || commit) && (boundary || !en);
    assign lit      = en && !({1'b0, d} < D_BLANK);
    assign row_sel  = ~({{(ROWS-1){1'b0}}, 1'b1} << (R_LAST - r));

    dot_matrix_framebuf #(.ROWS(ROWS), .COLS(COLS)) u_fb (
        .clk_div (clk_div),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r),
        .swap    (swap),
        .rd_data (rd_data)
    );

`ifdef DOT_MATRIX_SCROLL_EN
    localparam int CW = col_w(COLS);
    localparam logic [CW-1:0] C_LAST = CW'(COLS-1);
    logic [CW-1:0]     offset;
    logic [2*COLS-1:0] rot;

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst)
            offset <= '0;
        else if (boundary && scroll_en)
            offset <= scroll_left ? ((offset == C_LAST) ? '0 : offset + 1'b1)
                                  : ((offset == '0) ? C_LAST : offset - 1'b1);
    end

    assign rot      = {rd_data, rd_data} << offset;
    assign col_data = rot[2*COLS-1:COLS];
`else
    assign col_data = rd_data;
`endif

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            r              <= '0;
            d              <= '0;
            dot_row        <= BLANK_ROW[ROWS-1:0];
            dot_col        <= '0;
            frame_start    <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            commit_pending <= (commit_pending || commit) && !swap;
            frame_start    <= en && r == '0 && d == '0;
            dot_row        <= lit ? row_sel : BLANK_ROW[ROWS-1:0];
            dot_col        <= lit ? col_data : '0;
            d              <= (!en || d == D_LAST) ? '0 : d + 1'b1;
            r              <= !en ? '0 : (d != D_LAST) ? r : (r == R_LAST) ? '0 : r + 1'b1;
        end
    end
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb_dot_matrix_scanner: randomized scoreboard bench against a frame-level reference model.
module tb_dot_matrix_scanner;
    localparam int ROWS  = 10;
    localparam int COLS  = 8;
    localparam int DWELL = 3;
    localparam int BLANK = 1;
    localparam int FRAME = ROWS * DWELL;
    localparam int AW    = 4;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            fs;
        logic            pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [COLS-1:0] wr_data = '0;
    logic commit = 1'b0;
    logic commit_pending;
    logic frame_start;
    logic [ROWS-1:0] dot_row;
    logic [COLS-1:0] dot_col;

    always #5 clk = ~clk;

    dot_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk_div        (clk),
        .rst            (rst),
        .en             (en),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .frame_start    (frame_start),
        .dot_row        (dot_row),
        .dot_col        (dot_col)
    );

    exp_t q[$];
    exp_t rst_e;
    exp_t mon_e;
    int checks = 0;
    int passed = 0;

    // Reference state: position within the frame in cycles, plus two images that are physically exchanged.
    int pos = 0;
    logic pend = 1'b0;
    logic [COLS-1:0] front_m [ROWS];
    logic [COLS-1:0] back_m [ROWS];
    logic [COLS-1:0] pat [ROWS] = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E, 8'h55, 8'hAA};

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act === want)
            passed++;
        else
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("dot_row", 32'(dot_row), 32'(mon_e.row));
            chk("dot_col", 32'(dot_col), 32'(mon_e.col));
            chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
            chk("commit_pending", 32'(commit_pending), 32'(mon_e.pend));
        end
    end

    task automatic model_clear();
        pos = 0;
        pend = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            front_m[i] = '0;
            back_m[i] = '0;
        end
    endtask

    // Predict the outputs after the coming edge from the current inputs, then take that edge.
    task automatic tick();
        exp_t e;
        logic want, swap_now;
        logic [ROWS-1:0] one;
        logic [COLS-1:0] t;
        int r, d;
        one = '0;
        one[0] = 1'b1;
        if (!rst) begin
            model_clear();
            e = rst_e;
        end else begin
            r = pos / DWELL;
            d = pos % DWELL;
            if (en && d >= BLANK) begin
                e.row = ~(one << (ROWS - 1 - r));
                e.col = front_m[r];
            end else begin
                e.row = '1;
                e.col = '0;
            end
            e.fs = en && pos == 0;
            want = pend || commit;
            swap_now = want && (!en || pos == FRAME - 1);
            pos = en ? (pos + 1) % FRAME : 0;
            if (wr_en && int'(wr_addr) < ROWS)
                back_m[int'(wr_addr)] = wr_data;
            if (swap_now)
                for (int i = 0; i < ROWS; i++) begin
                    t = front_m[i];
                    front_m[i] = back_m[i];
                    back_m[i] = t;
                end
            pend = want && !swap_now;
            e.pend = pend;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        wr_en = 1'b0;
        commit = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(int a, logic [COLS-1:0] v);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Called just after an edge: the pending expectation for that edge must already show the reset.
    task automatic async_reset(int n);
        rst = 1'b0;
        model_clear();
        q.delete();
        q.push_back(rst_e);
        repeat (n) tick();
        rst = 1'b1;
    endtask

    initial begin
        rst_e = '{row: '1, col: '0, fs: 1'b0, pend: 1'b0};
        model_clear();
        idle(3);
        rst = 1'b1;
        en = 1'b1;
        idle(2 * FRAME);

        for (int i = 0; i < ROWS; i++)
            wr(i, pat[i]);
        pulse_commit();
        idle(2 * FRAME);

        wr(3, 8'hFF);
        idle(3 * FRAME);
        idle(FRAME / 2);
        pulse_commit();
        idle(2 * FRAME);

        while (pos != FRAME - 1)
            tick();
        commit = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 8'hA5;
        tick();
        idle(FRAME + 3);

        idle(7);
        commit = 1'b1;
        repeat (5) tick();
        idle(2 * FRAME);

        idle(11);
        en = 1'b0;
        idle(3);
        wr(5, 8'h3C);
        pulse_commit();
        idle(5);
        en = 1'b1;
        idle(2 * FRAME);

        for (int a = ROWS; a < 16; a++)
            wr(a, COLS'($urandom));
        wr(ROWS - 1, 8'h99);
        pulse_commit();
        idle(2 * FRAME);

        idle(13);
        async_reset(3);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            en = $urandom_range(0, 39) != 0;
            wr_en = $urandom_range(0, 3) == 0;
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = COLS'($urandom);
            commit = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 499) == 0)
                async_reset(2);
            else
                tick();
        end
        idle(2);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
